// File: rtl/lshift_8_feeder.sv
// lshift_8_feeder: FIFO-buffered, registered valid/ready wrapper around the combinational lshift_8
module lshift_8_feeder #(
  parameter int DEPTH = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic [2:0]    in_lsel,
  output logic [7:0]    shf_data,
  output logic [2:0]    shf_lsel,
  input  logic [7:0]    shf_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_data,
  output logic [2:0]    res_lsel,
  output logic [CW-1:0] count
);
  localparam int AW = CW - 1;
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push, pop, empty;
  always_comb begin
    empty    = count == '0;
    in_ready = count != CW'(DEPTH);
    push     = in_valid & in_ready;
    pop      = ~empty & (~res_valid | res_ready);
    shf_data = empty ? 8'h00 : mem[rptr][10:3];
    shf_lsel = empty ? 3'b000 : mem[rptr][2:0];
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {in_data, in_lsel};
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= 8'h00;
      res_lsel  <= 3'b000;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr      <= rptr + AW'(1);
        res_data  <= shf_out;
        res_lsel  <= shf_lsel;
        res_valid <= 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

module lshift_8 (
  input  logic [7:0] data,
  input  logic [2:0] lsel,
  output logic [7:0] out
);
  always_comb out = data << lsel;
endmodule

// File: tb/tb_lshift_8_feeder.sv
// tb_lshift_8_feeder: directed and random checks of lshift_8_feeder against a queue model
module tb_lshift_8_feeder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready, res_valid, res_ready = 1'b0;
  logic [7:0] in_data = 8'h00, shf_data, shf_out, res_data;
  logic [2:0] in_lsel = 3'b000, shf_lsel, res_lsel;
  logic [2:0] count;
  int         tests = 0, fails = 0;
  logic [7:0] qd[$];
  logic [2:0] ql[$];
  logic       m_rv = 1'b0;
  logic [7:0] m_rd = 8'h00;
  logic [2:0] m_rl = 3'b000;
  logic [7:0] sweep [8] = '{8'hA5, 8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80};
  always #5 clk = ~clk;
  lshift_8_feeder #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_lsel(in_lsel), .shf_data(shf_data), .shf_lsel(shf_lsel),
    .shf_out(shf_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_lsel(res_lsel), .count(count)
  );
  lshift_8 u_sh (.data(shf_data), .lsel(shf_lsel), .out(shf_out));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] shl(input logic [7:0] d, input logic [2:0] s);
    return 8'((16'(d) * (16'd1 << s)) % 256);
  endfunction
  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(qd.size() != 4));
    chk("count", 32'(count), 32'(qd.size()));
    chk("shf_data", 32'(shf_data), qd.size() ? 32'(qd[0]) : 32'h0);
    chk("shf_lsel", 32'(shf_lsel), ql.size() ? 32'(ql[0]) : 32'h0);
    chk("res_valid", 32'(res_valid), 32'(m_rv));
    chk("res_data", 32'(res_data), 32'(m_rd));
    chk("res_lsel", 32'(res_lsel), 32'(m_rl));
  endtask
  task automatic step(input logic iv, input logic [7:0] d, input logic [2:0] l, input logic rr);
    bit can_push, can_pop;
    in_valid = iv; in_data = d; in_lsel = l; res_ready = rr;
    #1;
    check_all();
    can_push = iv && qd.size() != 4;
    can_pop  = qd.size() != 0 && (!m_rv || rr);
    if (can_pop) begin
      m_rd = shl(qd[0], ql[0]);
      m_rl = ql[0];
      m_rv = 1'b1;
      void'(qd.pop_front());
      void'(ql.pop_front());
    end else if (m_rv && rr) m_rv = 1'b0;
    if (can_push) begin
      qd.push_back(d);
      ql.push_back(l);
    end
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    qd.delete(); ql.delete();
    m_rv = 1'b0; m_rd = 8'h00; m_rl = 3'b000;
  endtask
  initial begin
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_all();
    step(1, 8'hA5, 3'd1, 1);
    chk("t1_count_after_accept", 32'(count), 32'd1);
    step(0, 8'h00, 3'd0, 1);
    chk("t1_res_valid", 32'(res_valid), 32'd1);
    chk("t1_res_data", 32'(res_data), 32'h4A);
    chk("t1_res_lsel", 32'(res_lsel), 32'd1);
    chk("t1_count", 32'(count), 32'd0);
    step(0, 8'h00, 3'd0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 8'hA5, 3'(i), 1);
      if (i > 0) chk("t2_sweep", 32'(res_data), 32'(sweep[i-1]));
    end
    step(0, 8'h00, 3'd0, 1);
    chk("t2_sweep_last", 32'(res_data), 32'h80);
    chk("t2_valid_last", 32'(res_valid), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 3'd0, 1);
    for (int i = 0; i < 6; i++) step(1, 8'h01, 3'(i), 0);
    chk("t3_held", 32'(res_data), 32'h01);
    chk("t3_count_full", 32'(count), 32'd4);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 3'd0, 1);
    chk("t3_drained_valid", 32'(res_valid), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h11 * i), 3'(i + 2), 0);
    chk("t4_count_pre", 32'(count), 32'd3);
    step(1, 8'h3C, 3'd2, 1);
    chk("t4_count_same", 32'(count), 32'd3);
    chk("t4_res", 32'(res_data), 32'(shl(8'h11, 3'd3)));
    step(1, 8'h77, 3'd1, 0);
    chk("t5_full", 32'(count), 32'd4);
    chk("t5_in_ready_full", 32'(in_ready), 32'd0);
    step(1, 8'h99, 3'd5, 1);
    chk("t5_count_after", 32'(count), 32'd3);
    chk("t5_in_ready_after", 32'(in_ready), 32'd1);
    chk("t6_pre_valid", 32'(res_valid), 32'd1);
    do_reset();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_res_valid", 32'(res_valid), 32'd0);
    chk("t6_res_data", 32'(res_data), 32'h00);
    chk("t6_shf_data", 32'(shf_data), 32'h00);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    step(1, 8'hFF, 3'd4, 1);
    step(0, 8'h00, 3'd0, 1);
    chk("t6_res_f0", 32'(res_data), 32'hF0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom),
           1'($urandom_range(0, 9) < 6));
    for (int i = 0; i < 8; i++) step(0, 8'h00, 3'd0, 1);
    check_all();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lshift_8_feeder.md
Name: lshift_8_feeder

Overview:
- Sequential front/back end for the combinational 8-bit logical left shifter `lshift_8`.
- Accepts shift requests over a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Presents the FIFO head to `lshift_8` on the `shf_data`/`shf_lsel` ports.
- Registers the shifter's `out` into a result register with its own valid/ready handshake, giving the barrel shifter a registered, back-pressurable pipeline.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, minimum 2.
- CW, 3, width of the count output; equals log2(DEPTH)+1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  FIFO can accept a request.
- in_data  in  8  operand to shift.
- in_lsel  in  3  left-shift amount, 0..7.
- shf_data  out  8  to lshift_8 `data`; head operand.
- shf_lsel  out  3  to lshift_8 `lsel`; head shift amount.
- shf_out  in  8  from lshift_8 `out`.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  consumer accepts the result.
- res_data  out  8  registered shift result.
- res_lsel  out  3  shift amount that produced res_data.
- count  out  CW  number of requests held in the FIFO (excludes the result register).

Behaviour:
- Reset (rst=1 at the clock edge):
  - Read/write pointers and count go to 0.
  - res_valid=0, res_data=8'h00, res_lsel=3'b000.
  - Reset overrides every other event in that cycle.
  - Reset mid-operation discards all queued requests and any pending result; no result is produced for them.
- in_ready = (count != DEPTH). It is registered-state derived; no combinational path from res_ready.
- push = in_valid & in_ready. The entry {in_data, in_lsel} is written at the tail and the write pointer increments, wrapping at DEPTH.
- shf_data/shf_lsel are combinational from the head entry. They are forced to 8'h00/3'b000 when count==0.
- pop = (count != 0) & (~res_valid | res_ready).
  - On pop: res_data <= shf_out, res_lsel <= head lsel, res_valid <= 1, and the read pointer increments with wrap.
- Result handshake:
  - No pop and res_valid & res_ready: res_valid <= 0; res_data/res_lsel hold their values.
  - res_valid=1 and res_ready=0: res_data, res_lsel and res_valid hold stable.
- count update:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- No bypass:
  - A request pushed at edge N is poppable at edge N+1 at the earliest.
  - Minimum latency is in accept edge to res_valid visible = 1 cycle after the accept edge; the result is registered at edge N+1.
- Throughput is one result per cycle when res_ready stays high.
- Full boundary: with count==DEPTH, in_ready=0 even if a pop occurs in the same cycle. A push is never lost or overwritten.
- Empty boundary: with count==0, no pop occurs; res_valid falls after a handshake.
- Ordering: strict FIFO. Results leave in request order.
- The shift itself is done entirely by lshift_8: res_data = (data << lsel) truncated to 8 bits, zero fill.

Test Plan:
Every scenario uses a bench that instantiates lshift_8 between shf_data/shf_lsel and shf_out.
1. Single request, res_ready=1: in_data=8'hA5, in_lsel=1 accepted at edge N -> after edge N+1, res_valid=1, res_data=8'h4A, res_lsel=1; count returns to 0.
2. Back-to-back sweep: data 8'hA5, lsel 0..7 on consecutive cycles, res_ready=1 -> res_valid held high for 8 cycles with res_data 8'hA5, 8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80 in order.
3. Back-pressure fill: res_ready=0, in_valid=1 for 6 cycles (data 8'h01, lsel 0..5) ->
   - first result 8'h01 held in res_data;
   - count reaches 4 and in_ready=0;
   - 6th request not accepted.
   Then raise res_ready -> res_data sequence 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, then res_valid=0.
4. Simultaneous push/pop at count=3, res_valid=1, res_ready=1 -> count stays 3, one result consumed, order preserved.
5. Full with pop: count=4, res_ready=1, in_valid=1 -> in_ready=0 that cycle, count becomes 3, in_ready=1 next cycle.
6. Reset mid-operation: count=3, res_valid=1, assert rst for one edge ->
   - count=0, res_valid=0, res_data=8'h00, shf_data=8'h00, in_ready=1;
   - a subsequent request (8'hFF, lsel=4) yields res_data=8'hF0.
